// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory behind a valid/ready request/response handshake with fixed added latency
//   clock_i/reset_i   : single rising-edge clock, synchronous active-high reset
//   req_*_i/req_ready_o : request channel (store/load, byte address, store data, byte enables)
//   resp_*_o/resp_ready_i : response channel (load data, misaligned/out-of-range error)
//   dbg_addr_i/dbg_data_o : registered debug read port, 1-cycle latency, read-before-write
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_write_i,
  input  logic [31:0]   req_addr_i,
  input  logic [31:0]   req_wdata_i,
  input  logic [3:0]    req_be_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic [31:0]   resp_rdata_o,
  output logic          resp_err_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [31:0]   dbg_data_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic write_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] be_q;
  logic [31:0] rdata_q, rdata_d, dbg_q;
  logic err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};
  logic accept, enter_resp, err, wr_en;
  logic [AW-1:0] idx;
  assign accept = state_q == IDLE && req_valid_i;
  // counter runs down to zero so RESP is entered WAIT_CYCLES+1 edges after accept
  assign enter_resp = state_q == WAIT && cnt_q == 4'd0;
  assign idx = addr_q[AW+1:2];
  assign err = |addr_q[1:0] || |addr_q[31:AW+2];
  assign wr_en = enter_resp && write_q && !err;
  assign req_ready_o = state_q == IDLE;
  assign resp_valid_o = state_q == RESP;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o = err_q;
  assign dbg_data_o = dbg_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    state_d = accept ? WAIT : enter_resp ? RESP : (state_q == RESP && resp_ready_i) ? IDLE : state_q;
    cnt_d = accept ? 4'(WAIT_CYCLES) : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    rdata_d = enter_resp ? ((write_q || err) ? 32'd0 : mem_q[idx]) : rdata_q;
    err_d = enter_resp ? err : err_q;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
      dbg_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      dbg_q <= mem_q[dbg_addr_i];
    end
  end
  always_ff @(posedge clock_i) begin
    if (accept) begin
      write_q <= req_write_i;
      addr_q <= req_addr_i;
      wdata_q <= req_wdata_i;
      be_q <= req_be_i;
    end
  end
  // memory is never reset; a reset during WAIT suppresses the pending store
  always_ff @(posedge clock_i) begin
    if (!reset_i && wr_en)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem_q[idx][8*i+:8] <= wdata_q[8*i+:8];
  end
endmodule
